// File: rtl/flood_board_engine.sv
// Flood-it game engine: builds a pseudo-random board, then floods the region owned from [0][0] per color move.
// Latency: board generation takes final_SIZE^2 cycles; every flood settles in whole final_SIZE^2-cycle sweep passes.
// Backpressure: MOVE_READY is high only while waiting for a move; INIT_REQ preempts any state and any handshake.
module flood_board_engine #(
  parameter int          MAX_SIZE     = 26,
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic [4:0]  SIZE,
  input  logic [2:0]  NUM_COLORS,
  input  logic [15:0] SEED,
  input  logic        INIT_REQ,
  input  logic        MOVE_VALID,
  input  logic [2:0]  MOVE_COLOR,
  output logic        MOVE_READY,
  output logic [2:0]  GAME_BOARD [MAX_SIZE-1:0][MAX_SIZE-1:0],
  output logic [4:0]  final_SIZE,
  output logic        INIT_INIT,
  output logic [6:0]  MOVE_COUNT,
  output logic        WON
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SWEEP, S_READY, S_RECOLOR, S_DONE
  } state_t;

  localparam logic [4:0] SIZE_MAX = 5'(MAX_SIZE);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [2:0]  ncol;
  logic [2:0]  cur_color;
  logic [2:0]  mv_color;
  logic [4:0]  row, col;
  logic        changed;
  logic [9:0]  own_cnt;
  logic        owned [MAX_SIZE-1:0][MAX_SIZE-1:0];

  logic [4:0]  size_clamp;
  logic [2:0]  ncol_clamp;
  logic [15:0] seed_eff;
  logic        lfsr_fb;
  logic [2:0]  gen_color;
  logic [4:0]  last_idx;
  logic        last_cell;
  logic [9:0]  area;
  logic        move_acc;
  logic        move_real;
  logic [4:0]  row_dn, row_up, col_dn, col_up;
  logic        nbr_owned;
  logic        cell_hit;
  logic        any_change;

  // Input clamping, LFSR feedback and per-cell sweep decision
  always_comb begin
    size_clamp = SIZE;
    if (SIZE < 5'd2) size_clamp = 5'd2;
    else if (SIZE > SIZE_MAX) size_clamp = SIZE_MAX;
    ncol_clamp = (NUM_COLORS < 3'd2) ? 3'd2 : NUM_COLORS;
    seed_eff   = (SEED == 16'd0) ? LFSR_DEFAULT : SEED;
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    gen_color  = lfsr[2:0] % ncol;
    last_idx   = final_SIZE - 5'd1;
    last_cell  = (row == last_idx) && (col == last_idx);
    area       = 10'(final_SIZE) * 10'(final_SIZE);
    move_acc   = (state == S_READY) && MOVE_VALID && !INIT_REQ;
    move_real  = move_acc && (MOVE_COLOR != cur_color) && (MOVE_COLOR < ncol);
    // neighbour indices are clamped so they never leave the array; the guards below drop them at the board edge
    row_dn     = (row == 5'd0) ? row : row - 5'd1;
    row_up     = (row == last_idx) ? row : row + 5'd1;
    col_dn     = (col == 5'd0) ? col : col - 5'd1;
    col_up     = (col == last_idx) ? col : col + 5'd1;
    nbr_owned  = 1'b0;
    if (row != 5'd0     && owned[row_dn][col]) nbr_owned = 1'b1;
    if (row != last_idx && owned[row_up][col]) nbr_owned = 1'b1;
    if (col != 5'd0     && owned[row][col_dn]) nbr_owned = 1'b1;
    if (col != last_idx && owned[row][col_up]) nbr_owned = 1'b1;
    cell_hit   = (state == S_SWEEP) && !owned[row][col] &&
                 (GAME_BOARD[row][col] == cur_color) && nbr_owned;
    any_change = changed | cell_hit;
  end

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a new game request overrides everything
  always_comb begin
    state_nxt = state;
    if (INIT_REQ) begin
      state_nxt = S_GEN;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_GEN:     if (last_cell) state_nxt = S_SWEEP;
        S_SWEEP:   if (last_cell && !any_change)
                     state_nxt = (own_cnt == area) ? S_DONE : S_READY;
        S_READY:   if (move_real) state_nxt = S_RECOLOR;
        S_RECOLOR: state_nxt = S_SWEEP;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    MOVE_READY = 1'b0;
    WON        = 1'b0;
    if (state == S_READY) MOVE_READY = 1'b1;
    if (state == S_DONE)  WON        = 1'b1;
  end

  // Game configuration, LFSR and the row-major cell cursor shared by GEN and SWEEP
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      final_SIZE <= 5'd0;
      ncol       <= 3'd2;
      lfsr       <= LFSR_DEFAULT;
      row        <= 5'd0;
      col        <= 5'd0;
    end else if (INIT_REQ) begin
      final_SIZE <= size_clamp;
      ncol       <= ncol_clamp;
      lfsr       <= seed_eff;
      row        <= 5'd0;
      col        <= 5'd0;
    end else if (state == S_GEN || state == S_SWEEP) begin
      if (state == S_GEN) lfsr <= {lfsr[14:0], lfsr_fb};
      if (last_cell) begin
        row <= 5'd0;
        col <= 5'd0;
      end else if (col == last_idx) begin
        row <= row + 5'd1;
        col <= 5'd0;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

  // Board cells: cleared on a new game, filled during GEN, owned region repainted in RECOLOR
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          GAME_BOARD[r][c] <= 3'd0;
    end else if (INIT_REQ) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          GAME_BOARD[r][c] <= 3'd0;
    end else if (state == S_GEN) begin
      GAME_BOARD[row][col] <= gen_color;
    end else if (state == S_RECOLOR) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          if (owned[r][c]) GAME_BOARD[r][c] <= mv_color;
    end
  end

  // Owned region, its population count and the per-pass change flag
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          owned[r][c] <= 1'b0;
      own_cnt <= 10'd0;
      changed <= 1'b0;
    end else if (INIT_REQ) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          owned[r][c] <= 1'b0;
      own_cnt <= 10'd0;
      changed <= 1'b0;
    end else if (state == S_GEN && last_cell) begin
      owned[0][0] <= 1'b1;
      own_cnt     <= 10'd1;
      changed     <= 1'b0;
    end else if (state == S_SWEEP) begin
      if (cell_hit) begin
        owned[row][col] <= 1'b1;
        own_cnt         <= own_cnt + 10'd1;
      end
      if (last_cell)     changed <= 1'b0;
      else if (cell_hit) changed <= 1'b1;
    end
  end

  // Current flood color, pending move color, move counter and board-valid flag
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_color  <= 3'd0;
      mv_color   <= 3'd0;
      MOVE_COUNT <= 7'd0;
      INIT_INIT  <= 1'b0;
    end else if (INIT_REQ) begin
      MOVE_COUNT <= 7'd0;
      INIT_INIT  <= 1'b0;
    end else begin
      if (state == S_GEN && last_cell) cur_color <= GAME_BOARD[0][0];
      if (state == S_RECOLOR)          cur_color <= mv_color;
      if (move_real) begin
        mv_color <= MOVE_COLOR;
        if (MOVE_COUNT != 7'd127) MOVE_COUNT <= MOVE_COUNT + 7'd1;
      end
      if (state == S_SWEEP && (state_nxt == S_READY || state_nxt == S_DONE))
        INIT_INIT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flood_board_engine.sv
// Bench for flood_board_engine: reference game model feeds a scoreboard of expected settled states.
// Latency: checks GEN progress cycle-exactly, then waits (bounded) for each flood to settle.
// Backpressure: moves are offered only once MOVE_READY is seen; extra offers in DONE must be ignored.
module tb_flood_board_engine;

  localparam int MS = 26;
  localparam int BW = MS * MS * 3;

  typedef struct packed {
    logic [BW-1:0] board;
    logic [6:0]    mcnt;
    logic          won;
    logic [4:0]    fsize;
  } exp_t;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [4:0]  SIZE = 5'd0;
  logic [2:0]  NUM_COLORS = 3'd0;
  logic [15:0] SEED = 16'd0;
  logic        INIT_REQ = 1'b0;
  logic        MOVE_VALID = 1'b0;
  logic [2:0]  MOVE_COLOR = 3'd0;
  logic        MOVE_READY;
  logic [2:0]  GAME_BOARD [MS-1:0][MS-1:0];
  logic [4:0]  final_SIZE;
  logic        INIT_INIT;
  logic [6:0]  MOVE_COUNT;
  logic        WON;

  flood_board_engine #(.MAX_SIZE(MS), .LFSR_DEFAULT(16'hACE1)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .SIZE       (SIZE),
    .NUM_COLORS (NUM_COLORS),
    .SEED       (SEED),
    .INIT_REQ   (INIT_REQ),
    .MOVE_VALID (MOVE_VALID),
    .MOVE_COLOR (MOVE_COLOR),
    .MOVE_READY (MOVE_READY),
    .GAME_BOARD (GAME_BOARD),
    .final_SIZE (final_SIZE),
    .INIT_INIT  (INIT_INIT),
    .MOVE_COUNT (MOVE_COUNT),
    .WON        (WON)
  );

  always #5 CLOCK = ~CLOCK;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb [$];

  int m_board [MS][MS];
  bit m_own   [MS][MS];
  int m_size = 0, m_ncol = 2, m_cur = 0, m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Region owned from [0][0]: depth-first fill over same-colored in-bound neighbours
  function automatic void model_flood();
    int stk [$];
    int p, r, c, nr, nc;
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        m_own[i][j] = 1'b0;
    m_own[0][0] = 1'b1;
    stk.push_back(0);
    while (stk.size() > 0) begin
      p = stk.pop_back();
      r = p / MS;
      c = p % MS;
      for (int d = 0; d < 4; d++) begin
        nr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        nc = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        if (nr >= 0 && nr < m_size && nc >= 0 && nc < m_size &&
            !m_own[nr][nc] && m_board[nr][nc] == m_cur) begin
          m_own[nr][nc] = 1'b1;
          stk.push_back(nr * MS + nc);
        end
      end
    end
  endfunction

  function automatic void model_gen(input int size, input int ncol, input int seed);
    logic [15:0] l;
    m_size = (size < 2) ? 2 : ((size > MS) ? MS : size);
    m_ncol = (ncol < 2) ? 2 : ncol;
    l = (seed == 0) ? 16'hACE1 : 16'(seed);
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        m_board[r][c] = 0;
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++) begin
        m_board[r][c] = int'(l[2:0]) % m_ncol;
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
    m_cur = m_board[0][0];
    m_cnt = 0;
    model_flood();
  endfunction

  function automatic bit model_won();
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++)
        if (!m_own[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_move(input int color);
    if (color == m_cur || color >= m_ncol) return 1'b0;
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++)
        if (m_own[r][c]) m_board[r][c] = color;
    m_cur = color;
    if (m_cnt < 127) m_cnt++;
    model_flood();
    return 1'b1;
  endfunction

  // Expected board with only the first k in-bound cells (row-major) written
  function automatic logic [BW-1:0] pack(input int k);
    logic [BW-1:0] v;
    int i;
    v = '0;
    i = 0;
    for (int r = 0; r < m_size; r++)
      for (int c = 0; c < m_size; c++) begin
        if (i < k) v[(r * MS + c) * 3 +: 3] = 3'(m_board[r][c]);
        i++;
      end
    return v;
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.board = pack(m_size * m_size);
    e.mcnt  = 7'(m_cnt);
    e.won   = model_won();
    e.fsize = 5'(m_size);
    return e;
  endfunction

  function automatic int board_diff(input logic [BW-1:0] e);
    int n;
    n = 0;
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++)
        if (GAME_BOARD[r][c] !== e[(r * MS + c) * 3 +: 3]) n++;
    return n;
  endfunction

  function automatic int find_seed(input int size, input int ncol);
    for (int s = 1; s < 2000; s++) begin
      model_gen(size, ncol, s);
      if (!model_won()) return s;
    end
    return 1;
  endfunction

  task automatic wait_settle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(INIT_INIT && (MOVE_READY || WON)) && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check_eq({tag, " settled"}, 32'(INIT_INIT && (MOVE_READY || WON)), 1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check_eq({tag, " sb_depth"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_eq({tag, " board"},      board_diff(e.board), 0);
    check_eq({tag, " move_count"}, MOVE_COUNT, e.mcnt);
    check_eq({tag, " won"},        WON, e.won);
    check_eq({tag, " move_ready"}, MOVE_READY, !e.won);
    check_eq({tag, " final_size"}, final_SIZE, e.fsize);
    check_eq({tag, " init_init"},  INIT_INIT, 1);
  endtask

  // Starts a game; optionally offers a move in the same cycle, or abandons it abort_at cycles in
  task automatic do_init(input string tag, input int size, input int ncol, input int seed,
                         input int move_col, input int abort_at);
    int n2;
    @(negedge CLOCK);
    SIZE       = 5'(size);
    NUM_COLORS = 3'(ncol);
    SEED       = 16'(seed);
    INIT_REQ   = 1'b1;
    if (move_col >= 0) begin
      MOVE_VALID = 1'b1;
      MOVE_COLOR = 3'(move_col);
    end
    model_gen(size, ncol, seed);
    n2 = m_size * m_size;
    if (abort_at == 0) sb.push_back(mk_exp());
    @(negedge CLOCK);
    INIT_REQ   = 1'b0;
    MOVE_VALID = 1'b0;
    check_eq({tag, " init_init_drop"}, INIT_INIT, 0);
    check_eq({tag, " cleared"},        board_diff(pack(0)), 0);
    check_eq({tag, " count_clr"},      MOVE_COUNT, 0);
    check_eq({tag, " fsize"},          final_SIZE, m_size);
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge CLOCK);
      check_eq({tag, " still_busy"}, INIT_INIT, 0);
      return;
    end
    @(negedge CLOCK);
    check_eq({tag, " gen_first"},    board_diff(pack(1)), 0);
    check_eq({tag, " gen_not_ready"}, MOVE_READY, 0);
    repeat (n2 - 2) @(negedge CLOCK);
    check_eq({tag, " gen_n2m1"}, board_diff(pack(n2 - 1)), 0);
    @(negedge CLOCK);
    check_eq({tag, " gen_full"}, board_diff(pack(n2)), 0);
    wait_settle(tag, 30000);
    pop_compare(tag);
  endtask

  task automatic do_move(input string tag, input int color);
    bit real_mv;
    int n;
    n = 0;
    while (!MOVE_READY && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    check_eq({tag, " ready"}, MOVE_READY, 1);
    MOVE_VALID = 1'b1;
    MOVE_COLOR = 3'(color);
    real_mv = model_move(color);
    sb.push_back(mk_exp());
    @(negedge CLOCK);
    MOVE_VALID = 1'b0;
    check_eq({tag, " ready_after"}, MOVE_READY, 32'(!real_mv));
    wait_settle(tag, 20000);
    pop_compare(tag);
  endtask

  int seed, k;
  int acc_b, acc_f, acc_i, acc_r, acc_m, acc_w;

  initial begin
    // reset values
    repeat (2) @(negedge CLOCK);
    check_eq("rst board",      board_diff(pack(0)), 0);
    check_eq("rst final_size", final_SIZE, 0);
    check_eq("rst init_init",  INIT_INIT, 0);
    check_eq("rst move_ready", MOVE_READY, 0);
    check_eq("rst move_count", MOVE_COUNT, 0);
    check_eq("rst won",        WON, 0);
    RESET_N = 1'b1;

    // idle without a game request
    acc_b = 0; acc_f = 0; acc_i = 0; acc_r = 0; acc_m = 0; acc_w = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      acc_b += board_diff(pack(0));
      acc_f += int'(final_SIZE != 5'd0);
      acc_i += int'(INIT_INIT);
      acc_r += int'(MOVE_READY);
      acc_m += int'(MOVE_COUNT != 7'd0);
      acc_w += int'(WON);
    end
    check_eq("idle board",      acc_b, 0);
    check_eq("idle final_size", acc_f, 0);
    check_eq("idle init_init",  acc_i, 0);
    check_eq("idle move_ready", acc_r, 0);
    check_eq("idle move_count", acc_m, 0);
    check_eq("idle won",        acc_w, 0);

    // minimum clamps, default seed
    do_init("min_clamp", 0, 1, 0, -1, 0);
    // maximum clamp, full-size board
    do_init("max_clamp", 31, 7, 16'h1234, -1, 0);

    // no-op moves, then a real move
    seed = find_seed(4, 4);
    do_init("noop", 4, 4, seed, -1, 0);
    do_move("noop_cur", m_cur);
    do_move("noop_c7", 7);
    do_move("recolor", (m_cur + 1) % m_ncol);

    // 2x2 two-color game to completion
    seed = find_seed(2, 2);
    do_init("win", 2, 2, seed, -1, 0);
    k = 0;
    while (!WON && k < 4) begin
      do_move("win_mv", 1 - m_cur);
      k++;
    end
    check_eq("win won",       WON, 1);
    check_eq("win moves_le3", 32'(k <= 3), 1);
    sb.push_back(mk_exp());
    MOVE_VALID = 1'b1;
    MOVE_COLOR = 3'(1 - m_cur);
    repeat (5) @(negedge CLOCK);
    MOVE_VALID = 1'b0;
    pop_compare("done_ignore");

    // asynchronous reset in the middle of generation
    do_init("rst_gen", 8, 5, 321, -1, 10);
    @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check_eq("midrst board",      board_diff(pack(0)), 0);
    check_eq("midrst final_size", final_SIZE, 0);
    check_eq("midrst move_ready", MOVE_READY, 0);
    repeat (3) @(negedge CLOCK);
    check_eq("midrst board_hold", board_diff(pack(0)), 0);
    RESET_N = 1'b1;

    // new game wins over a same-cycle move, and aborts a running sweep
    seed = find_seed(4, 3);
    do_init("pre_abort", 4, 3, seed, -1, 0);
    do_init("init_vs_move", 4, 3, seed + 5, (m_cur + 1) % m_ncol, 0);
    do_init("sweep_abort", 8, 7, 77, -1, 66);
    do_init("restart", 5, 3, 99, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flood_board_engine.md
FLOOD_BOARD_ENGINE -- requirements
Module: flood_board_engine

Interface
REQ-001 Parameter MAX_SIZE, default 26: maximum board dimension and array extent.
REQ-002 Parameter LFSR_DEFAULT, default 16'hACE1: LFSR seed used when SEED is zero.
REQ-003 CLOCK  input  1  single clock; all state on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SIZE  input  5  requested board dimension; sampled only on INIT_REQ.
REQ-006 NUM_COLORS  input  3  requested color count; sampled only on INIT_REQ.
REQ-007 SEED  input  16  LFSR seed; sampled only on INIT_REQ.
REQ-008 INIT_REQ  input  1  single-cycle pulse that starts a new game.
REQ-009 MOVE_VALID  input  1  move offered.
REQ-010 MOVE_COLOR  input  3  color of offered move.
REQ-011 MOVE_READY  output  1  engine can accept a move.
REQ-012 GAME_BOARD  output  3 per cell, unpacked [MAX_SIZE-1:0][MAX_SIZE-1:0] indexed [row][col]  cell colors for the VGA display.
REQ-013 final_SIZE  output  5  latched board dimension.
REQ-014 INIT_INIT  output  1  board valid for display.
REQ-015 MOVE_COUNT  output  7  accepted color-changing moves.
REQ-016 WON  output  1  all in-bound cells owned.

Function
REQ-017 On INIT_REQ, latch final_SIZE = SIZE clamped to [2, MAX_SIZE] and NUM_COLORS clamped to [2,7]; value 0 is treated as 8 only when NUM_COLORS = 0 is excluded, so NUM_COLORS in {0,1} becomes 2.
REQ-018 INIT_REQ is honoured in every non-reset state, aborts any operation, and wins over a same-cycle move handshake.
REQ-019 On INIT_REQ: clear MOVE_COUNT, WON, INIT_INIT, all owned bits and every GAME_BOARD cell; load LFSR with SEED, or LFSR_DEFAULT when SEED = 0.
REQ-020 States: IDLE, GEN, SWEEP, READY, RECOLOR, DONE.
REQ-021 IDLE: entered from reset; MOVE_READY = 0; leaves only on INIT_REQ, going to GEN.
REQ-022 GEN: one cell per cycle, row-major over rows and columns 0..final_SIZE-1.
REQ-023 GEN: on each cycle, cell = LFSR[2:0] mod latched color count, then the LFSR advances.
REQ-024 GEN: the LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11, shifting left with feedback into bit 0.
REQ-025 GEN: takes exactly final_SIZE^2 cycles.
REQ-026 GEN exit: owned[0][0] is set, cur_color = GAME_BOARD[0][0], and the state goes to SWEEP.
REQ-027 Cells outside final_SIZE stay 0 and are never owned.
REQ-028 SWEEP: visits one in-bound cell per cycle, row-major.
REQ-029 SWEEP: a visited cell that is not owned, has color equal to cur_color, and has any owned in-bound 4-neighbour becomes owned, and the changed flag is set.
REQ-030 End of a SWEEP pass: if the changed flag is set, clear it and start a new pass; otherwise go to DONE if owned count = final_SIZE^2, else READY.
REQ-031 INIT_INIT rises on the first transition into READY or DONE after GEN and stays high until the next INIT_REQ or reset.
REQ-032 READY: MOVE_READY = 1; a move is accepted on a cycle where MOVE_VALID and MOVE_READY are both high.
REQ-033 An accepted move with MOVE_COLOR = cur_color or MOVE_COLOR >= color count is a no-op: the state stays READY and MOVE_COUNT is unchanged.
REQ-034 Any other accepted move goes to RECOLOR and increments MOVE_COUNT, saturating at 127.
REQ-035 RECOLOR lasts one cycle: all owned cells are written with MOVE_COLOR in parallel, cur_color = MOVE_COLOR, then the state goes to SWEEP.
REQ-036 DONE: WON = 1, MOVE_READY = 0; leaves only on INIT_REQ.
REQ-037 MOVE_READY is 0 in every state except READY.
REQ-038 GAME_BOARD, final_SIZE and INIT_INIT are register outputs with no combinational path from any input.
REQ-039 The owned count is kept in a 10-bit register that increments on each newly owned cell.

Reset
REQ-040 While RESET_N = 0, the block is held in IDLE with all outputs cleared.
REQ-041 Reset values: GAME_BOARD all 0, final_SIZE = 0, INIT_INIT = 0, MOVE_READY = 0, MOVE_COUNT = 0, WON = 0.
REQ-042 Reset also clears all owned bits, cur_color and the changed flag, and loads the LFSR with LFSR_DEFAULT.
REQ-043 Reset asserted mid-GEN or mid-SWEEP takes effect immediately, with no partial writes after assertion.

Verification
REQ-044 Reset release, no INIT_REQ for 100 cycles -> all outputs stay 0 and MOVE_READY = 0.
REQ-045 INIT_REQ with SIZE=0, NUM_COLORS=1, SEED=0 -> final_SIZE=2; GEN completes in 4 cycles; cells match the LFSR model from 16'hACE1 with mod 2; INIT_INIT=1 once the sweeps end.
REQ-046 SIZE=31 -> final_SIZE=26; all cells [r][c] with r or c >= 26 are 0; GEN takes 676 cycles.
REQ-047 From READY, MOVE_COLOR=cur_color, then MOVE_COLOR=7 with 4 colors -> both are accepted for one cycle, MOVE_COUNT stays 0, the board is unchanged, and MOVE_READY returns high.
REQ-048 2x2 board, 2 colors, alternate colors until done -> WON=1 within 3 moves, MOVE_READY=0, all four cells equal; further MOVE_VALID is ignored.
REQ-049 INIT_REQ asserted together with MOVE_VALID in READY, and INIT_REQ asserted mid-SWEEP -> the move is not counted, MOVE_COUNT=0, INIT_INIT drops the next cycle, and GEN restarts from cell [0][0].
